// File: rtl/cdb_arbiter_if.sv
// Requester/broadcast bundle for one common data bus.
// The arbiter uses the slave modport; execution units and consumers use master.
interface cdb_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int ROB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ*ROB_WIDTH-1:0]  req_tag;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic                        cdb_valid;
    logic [ROB_WIDTH-1:0]        cdb_tag;
    logic [DATA_WIDTH-1:0]       cdb_data;

    modport slave (
        input  req_valid, req_tag, req_data,
        output req_ready, cdb_valid, cdb_tag, cdb_data
    );

    modport master (
        output req_valid, req_tag, req_data,
        input  req_ready, cdb_valid, cdb_tag, cdb_data
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for one CDB: grants one producer per cycle and
// broadcasts its tag/data one cycle later; late producers supply payload then.
module cdb_arbiter #(
    parameter int               N_REQ      = 4,
    parameter int               ROB_WIDTH  = 4,
    parameter int               DATA_WIDTH = 32,
    parameter logic [N_REQ-1:0] LATE_MASK  = N_REQ'(1)
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         flush_i,
    cdb_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [ROB_WIDTH-1:0]  tag_arr  [N_REQ];
    logic [DATA_WIDTH-1:0] data_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign tag_arr[gi]  = bus.req_tag[gi*ROB_WIDTH +: ROB_WIDTH];
            assign data_arr[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic                  g_valid_q, g_valid_d;
    logic [IDX_W-1:0]      g_idx_q, g_idx_d;
    logic                  g_late_q, g_late_d;
    logic [ROB_WIDTH-1:0]  g_tag_q, g_tag_d;
    logic [DATA_WIDTH-1:0] g_data_q, g_data_d;
    logic [ROB_WIDTH-1:0]  hold_tag_q, hold_tag_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

    logic                  grant_found;
    logic [IDX_W-1:0]      grant_idx;
    logic [N_REQ-1:0]      grant_vec;
    int                    scan_idx;

    // Scan upward from the requester after the last winner, wrapping once.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        scan_idx    = 0;
        if (!reset_i && !flush_i) begin
            for (int k = 0; k < N_REQ; k++) begin
                scan_idx = int'(last_grant_q) + 1 + k;
                if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
                if (!grant_found && bus.req_valid[scan_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = IDX_W'(scan_idx);
                end
            end
        end
        if (grant_found) grant_vec[grant_idx] = 1'b1;
    end

    assign bus.req_ready = grant_vec;

    always_comb begin
        last_grant_d = grant_found ? grant_idx : last_grant_q;
        g_valid_d    = grant_found;
        g_idx_d      = grant_idx;
        g_late_d     = LATE_MASK[grant_idx];
        g_tag_d      = g_tag_q;
        g_data_d     = g_data_q;
        if (grant_found && !LATE_MASK[grant_idx]) begin
            g_tag_d  = tag_arr[grant_idx];
            g_data_d = data_arr[grant_idx];
        end
    end

    // Late producers are read live in the broadcast cycle, early ones from the grant snapshot.
    logic [ROB_WIDTH-1:0]  bc_tag;
    logic [DATA_WIDTH-1:0] bc_data;
    logic                  bc_valid;

    always_comb begin
        bc_tag      = g_late_q ? tag_arr[g_idx_q]  : g_tag_q;
        bc_data     = g_late_q ? data_arr[g_idx_q] : g_data_q;
        bc_valid    = g_valid_q && !flush_i && !reset_i;
        hold_tag_d  = bc_valid ? bc_tag  : hold_tag_q;
        hold_data_d = bc_valid ? bc_data : hold_data_q;
    end

    assign bus.cdb_valid = bc_valid;
    assign bus.cdb_tag   = hold_tag_d;
    assign bus.cdb_data  = hold_data_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_grant_q <= IDX_W'(N_REQ - 1);
            g_valid_q    <= 1'b0;
            g_idx_q      <= '0;
            g_late_q     <= 1'b0;
            g_tag_q      <= '0;
            g_data_q     <= '0;
            hold_tag_q   <= '0;
            hold_data_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            g_valid_q    <= g_valid_d;
            g_idx_q      <= g_idx_d;
            g_late_q     <= g_late_d;
            g_tag_q      <= g_tag_d;
            g_data_q     <= g_data_d;
            hold_tag_q   <= hold_tag_d;
            hold_data_q  <= hold_data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert ($countones(grant_vec) <= 1);
            assert ((grant_vec & ~bus.req_valid) == '0);
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: round-robin order, late payload, flush and reset.
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int TW = 4;
    localparam int DW = 32;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;
    logic flush_i = 1'b0;

    int checks_cnt = 0;
    int errors_cnt = 0;

    cdb_arbiter_if #(.N_REQ(N), .ROB_WIDTH(TW), .DATA_WIDTH(DW)) bus ();

    cdb_arbiter #(
        .N_REQ(N), .ROB_WIDTH(TW), .DATA_WIDTH(DW), .LATE_MASK(4'b0001)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .flush_i(flush_i),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic set_req(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        bus.req_tag[i*TW +: TW]  = t;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic next_cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk_i);
    endtask

    int exp_idx [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        bus.req_valid = '0;
        bus.req_tag   = '0;
        bus.req_data  = '0;
        for (int i = 0; i < N; i++) set_req(i, TW'(i + 1), 32'hA0 + 32'(i));

        // Reset state
        next_cyc();
        at_neg();
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        check("rst_cdbv", 32'(bus.cdb_valid), 32'h0);
        check("rst_tag", 32'(bus.cdb_tag), 32'h0);
        check("rst_data", bus.cdb_data, 32'h0);

        // All valid: round-robin 0,1,2,3,0,1
        next_cyc();
        reset_i = 1'b0;
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            at_neg();
            check($sformatf("rr_ready%0d", c), 32'(bus.req_ready), 32'(1 << exp_idx[c]));
            check($sformatf("rr_cdbv%0d", c), 32'(bus.cdb_valid), (c > 0) ? 32'h1 : 32'h0);
            if (c > 0) begin
                check($sformatf("rr_tag%0d", c), 32'(bus.cdb_tag), 32'(exp_idx[c-1] + 1));
                check($sformatf("rr_data%0d", c), bus.cdb_data, 32'hA0 + 32'(exp_idx[c-1]));
            end
            next_cyc();
        end
        bus.req_valid = '0;
        at_neg();
        check("rr_tail_ready", 32'(bus.req_ready), 32'h0);
        check("rr_tail_cdbv", 32'(bus.cdb_valid), 32'h1);
        check("rr_tail_tag", 32'(bus.cdb_tag), 32'h2);
        next_cyc();
        at_neg();
        check("idle_cdbv", 32'(bus.cdb_valid), 32'h0);
        check("idle_hold_tag", 32'(bus.cdb_tag), 32'h2);

        // Single requester 2, granted every cycle
        next_cyc();
        bus.req_valid = 4'b0100;
        set_req(2, 4'd5, 32'h12345678);
        for (int c = 0; c < 3; c++) begin
            at_neg();
            check($sformatf("solo_ready%0d", c), 32'(bus.req_ready), 32'h4);
            check($sformatf("solo_cdbv%0d", c), 32'(bus.cdb_valid), (c > 0) ? 32'h1 : 32'h0);
            if (c > 0) begin
                check($sformatf("solo_tag%0d", c), 32'(bus.cdb_tag), 32'h5);
                check($sformatf("solo_data%0d", c), bus.cdb_data, 32'h12345678);
            end
            next_cyc();
        end
        bus.req_valid = '0;
        at_neg();
        check("solo_last_cdbv", 32'(bus.cdb_valid), 32'h1);
        check("solo_last_tag", 32'(bus.cdb_tag), 32'h5);
        check("solo_last_data", bus.cdb_data, 32'h12345678);

        // Late requester 0 then early requester 1 back-to-back
        next_cyc();
        bus.req_valid = 4'b0001;
        set_req(0, 4'd1, 32'h0);
        at_neg();
        check("late_ready", 32'(bus.req_ready), 32'h1);
        check("late_cdbv0", 32'(bus.cdb_valid), 32'h0);
        next_cyc();
        bus.req_valid = 4'b0010;
        set_req(0, 4'd1, 32'hDEADBEEF);
        set_req(1, 4'd3, 32'h33);
        at_neg();
        check("early_ready", 32'(bus.req_ready), 32'h2);
        check("late_cdbv1", 32'(bus.cdb_valid), 32'h1);
        check("late_data", bus.cdb_data, 32'hDEADBEEF);
        check("late_tag", 32'(bus.cdb_tag), 32'h1);
        next_cyc();
        bus.req_valid = '0;
        at_neg();
        check("early_cdbv", 32'(bus.cdb_valid), 32'h1);
        check("early_tag", 32'(bus.cdb_tag), 32'h3);
        check("early_data", bus.cdb_data, 32'h33);

        // Flush kills the grant in its own cycle
        next_cyc();
        bus.req_valid = 4'b0011;
        flush_i = 1'b1;
        at_neg();
        check("flush_ready", 32'(bus.req_ready), 32'h0);
        check("flush_cdbv", 32'(bus.cdb_valid), 32'h0);
        next_cyc();
        flush_i = 1'b0;
        at_neg();
        check("postflush_ready", 32'(bus.req_ready), 32'h1);
        check("postflush_cdbv", 32'(bus.cdb_valid), 32'h0);
        next_cyc();
        bus.req_valid = '0;
        at_neg();
        check("postflush_bc_v", 32'(bus.cdb_valid), 32'h1);
        check("postflush_bc_tag", 32'(bus.cdb_tag), 32'h1);

        // Grant to 3, flush drops its broadcast, pointer still advances
        next_cyc();
        set_req(3, 4'd7, 32'h77);
        bus.req_valid = 4'b1000;
        at_neg();
        check("g3_ready", 32'(bus.req_ready), 32'h8);
        next_cyc();
        bus.req_valid = '0;
        flush_i = 1'b1;
        at_neg();
        check("g3_drop_cdbv", 32'(bus.cdb_valid), 32'h0);
        check("g3_drop_ready", 32'(bus.req_ready), 32'h0);
        check("g3_drop_hold", 32'(bus.cdb_tag), 32'h1);
        next_cyc();
        flush_i = 1'b0;
        bus.req_valid = 4'b1111;
        at_neg();
        check("after3_ready", 32'(bus.req_ready), 32'h1);
        check("after3_cdbv", 32'(bus.cdb_valid), 32'h0);
        next_cyc();
        bus.req_valid = '0;
        at_neg();
        check("after3_bc_tag", 32'(bus.cdb_tag), 32'h1);

        // Reset right after a grant discards it
        next_cyc();
        bus.req_valid = 4'b1111;
        at_neg();
        check("pre_rst_ready", 32'(bus.req_ready), 32'h2);
        next_cyc();
        reset_i = 1'b1;
        at_neg();
        check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        check("mid_rst_cdbv", 32'(bus.cdb_valid), 32'h0);
        next_cyc();
        reset_i = 1'b0;
        at_neg();
        check("post_rst_ready", 32'(bus.req_ready), 32'h1);
        check("post_rst_cdbv", 32'(bus.cdb_valid), 32'h0);
        check("post_rst_tag", 32'(bus.cdb_tag), 32'h0);
        next_cyc();
        bus.req_valid = '0;
        at_neg();
        check("post_rst_bc_v", 32'(bus.cdb_valid), 32'h1);
        check("post_rst_bc_data", bus.cdb_data, 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares one common data bus (GPR or FPR CDB) among N_REQ result producers: load/store unit, ALUs, FPU, branch unit.
- Each requester raises valid. The arbiter grants at most one per cycle through ready, round-robin, and broadcasts the winner's tag/data on the CDB one cycle after the grant.
- Requesters flagged "late", such as the load/store unit, which registers its result after dispatch, supply their payload in the cycle after the grant rather than the grant cycle.
- One instance per CDB, between the execution units and the reservation stations/ROB.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ROB_WIDTH, 4, tag width (ROB index).
- DATA_WIDTH, 32, payload width.
- LATE_MASK, 4'b0001, bit i=1: requester i presents tag/data in the cycle after its grant; bit i=0: in the grant cycle.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- flush, input, 1, pipeline flush (mispredict); kills grants and broadcast in the same cycle.
- req_valid, input, N_REQ, request from requester i.
- req_ready, output, N_REQ, one-hot-or-zero grant; the handshake for requester i completes when req_valid[i] && req_ready[i].
- req_tag, input, N_REQ*ROB_WIDTH, tag of requester i, slice [i*ROB_WIDTH +: ROB_WIDTH].
- req_data, input, N_REQ*DATA_WIDTH, payload of requester i, slice [i*DATA_WIDTH +: DATA_WIDTH].
- cdb_valid, output, 1, broadcast valid.
- cdb_tag, output, ROB_WIDTH, broadcast tag.
- cdb_data, output, DATA_WIDTH, broadcast data.

Behaviour:
- Reset:
  - req_ready=0, cdb_valid=0.
  - cdb_tag/cdb_data=0.
  - Round-robin pointer last_grant=N_REQ-1, so requester 0 has first priority.
  - Grant pipeline register empty.
  - Reset has priority over flush and over all requests.
  - Reset mid-operation discards any granted-but-not-broadcast payload; no cdb_valid is produced for it.
- Arbitration (combinational, cycle T):
  - Scan from (last_grant+1) mod N_REQ upward with wrap-around.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all others get 0.
  - req_ready does not depend on flush in any other way: if flush=1 or reset=1, req_ready=0.
  - req_ready[i] may rise only when req_valid[i]=1. Requesters must hold valid, tag and data stable until granted.
- State update on a grant in T:
  - last_grant<=i.
  - g_valid<=1, g_idx<=i, g_late<=LATE_MASK[i].
  - If not late: g_tag<=req_tag[i], g_data<=req_data[i].
  - No grant: g_valid<=0, pointer unchanged.
- Broadcast (cycle T+1):
  - cdb_valid = g_valid && !flush.
  - If g_late=0: cdb_tag/cdb_data = registered g_tag/g_data.
  - If g_late=1: cdb_tag/cdb_data = req_tag/req_data slice g_idx, combinationally in T+1.
  - A late requester drives its payload in T+1 regardless of its req_valid in T+1.
  - When cdb_valid=0, cdb_tag/cdb_data hold their last value; consumers must ignore them.
- Throughput and latency:
  - One grant per cycle, back-to-back grants allowed, including late then early and early then late. Both paths coexist because each broadcast uses only its own grant-cycle state.
  - Grant-to-broadcast latency is exactly 1 cycle.
- Fairness:
  - A continuously requesting requester is granted within N_REQ cycles, provided flush is not asserted.
  - With a single requester active, it is granted every cycle.
- Flush:
  - A grant made in T-1 whose broadcast lands in a flush cycle T is dropped: cdb_valid=0. The requester considers it delivered because its handshake already completed.
  - There is no grant in the flush cycle itself, so cdb_valid=0 in T+1.
- Tag width:
  - Tags pass through unmodified. No tag comparison is done here.
- Assertions in simulation:
  - popcount(req_ready)<=1.
  - req_ready[i] implies req_valid[i].

Test Plan:
- Reset, then req_valid=4'b1111 held 6 cycles -> grants 0,1,2,3,0,1. cdb_valid=1 from cycle 2 on, each cdb_tag matching the previous cycle's winner.
- Only requester 2 valid, tag=5, data=0x12345678, for 3 cycles -> req_ready=4'b0100 each cycle. Three broadcasts of tag 5 / 0x12345678, each one cycle after its grant.
- Late requester 0 granted in T with req_data=0 in T and 0xDEADBEEF in T+1 -> cdb_data=0xDEADBEEF in T+1. Early requester 1 granted in T+1 with tag 3 -> cdb_tag=3 in T+2.
- req_valid=4'b0011 and flush=1 in T -> req_ready=0 in T, cdb_valid=0 in T+1. flush=0 in T+1 -> requester 0 granted in T+1.
- Grant to requester 3 (tag 7) in T, flush=1 in T+1 -> cdb_valid=0 in T+1 and last_grant=3. With all requesters valid in T+2, requester 0 is granted.
- reset=1 in the cycle after a grant -> cdb_valid=0 and req_ready=0 that cycle. After release, requester 0 has priority.
